pipe_div: RTL and testbench



---
 rtl/pipe_div_pkg.sv | 18 +
 rtl/pipe_div_step.sv | 26 ++
 rtl/pipe_div.sv | 70 +++++++
 tb/tb_pipe_div.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_div_pkg.sv
// Shared widths and the per-stage record for the pipelined restoring divider.
package pipe_div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  // One pipeline slot. The record is sized by the defaults above, so a width
  // change is made here rather than by overriding the top-level parameters.
  typedef struct packed {
    logic                      valid;
    logic                      dbz;
    logic [DEF_DIVIDEND_W-1:0] dividend;
    logic [DEF_DIVISOR_W-1:0]  divisor;
    logic [DEF_DIVISOR_W:0]    pr;
    logic [DEF_DIVIDEND_W-1:0] q;
  } stage_t;

endpackage

// File: rtl/pipe_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module pipe_div_step
  import pipe_div_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  // Only the low bits of the partial remainder are needed: the top bit is
  // always shifted out, and it is zero whenever the divisor is nonzero.
  input  logic [DIVISOR_W-1:0] pr,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;

  // Compare-and-restore on the shifted partial remainder.
  always_comb begin
    shifted = {pr, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    pr_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/pipe_div.sv
// Fully pipelined unsigned restoring divider: one quotient bit per stage,
// MSB first, one operation accepted per clock with no backpressure.
module pipe_div
  import pipe_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  // stg[0] holds the captured operands; stg[k] holds the result of step k.
  stage_t                stg    [0:DIVIDEND_W];
  logic [DIVISOR_W:0]    pr_nx  [1:DIVIDEND_W];
  logic [DIVIDEND_W:1]   q_bits;

  for (genvar k = 1; k <= DIVIDEND_W; k++) begin : g_step
    pipe_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .pr           (stg[k-1].pr[DIVISOR_W-1:0]),
      .dividend_bit (stg[k-1].dividend[DIVIDEND_W-k]),
      .divisor      (stg[k-1].divisor),
      .pr_next      (pr_nx[k]),
      .q_bit        (q_bits[k])
    );
  end

  // Advance every stage each clock; the final stage loads the output
  // registers only when it carries a valid operation, so outputs hold
  // between results. Reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DIVIDEND_W; i++) begin
        stg[i] <= '0;
      end
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      stg[0].valid    <= in_valid;
      stg[0].dbz      <= (divisor == '0);
      stg[0].dividend <= dividend;
      stg[0].divisor  <= divisor;
      stg[0].pr       <= '0;
      stg[0].q        <= '0;
      for (int k = 1; k <= DIVIDEND_W; k++) begin
        stg[k]    <= stg[k-1];
        stg[k].pr <= pr_nx[k];
        stg[k].q  <= {stg[k-1].q[DIVIDEND_W-2:0], q_bits[k]};
      end
      out_valid <= stg[DIVIDEND_W].valid;
      if (stg[DIVIDEND_W].valid) begin
        // A zero divisor is reported explicitly rather than relying on
        // whatever the subtract chain happened to leave behind.
        quotient    <= stg[DIVIDEND_W].dbz ? '1 : stg[DIVIDEND_W].q;
        remainder   <= stg[DIVIDEND_W].dbz ? '0 : stg[DIVIDEND_W].pr[DIVISOR_W-1:0];
        div_by_zero <= stg[DIVIDEND_W].dbz;
      end
    end
  end

endmodule

// File: tb/tb_pipe_div.sv
// Self-checking bench for pipe_div (8-bit dividend, 4-bit divisor).
module tb_pipe_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t expq[$];

  pipe_div dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Outputs are observed and inputs changed at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [3:0] b);
    in_valid = v;
    dividend = a;
    divisor  = b;
  endtask

  // Behavioural reference: plain integer division, all-ones on zero divisor.
  function automatic exp_t model(input int due, input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.due = due;
    e.a   = a;
    e.b   = b;
    if (b == 0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1;
    end else begin
      e.q = 8'(int'(a) / int'(b)); e.r = 4'(int'(a) % int'(b)); e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 8'd200, 4'd7);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({out_valid, quotient, remainder, div_by_zero} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b q=%0d r=%0d z=%b want all zero",
               out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    drive(0, 8'd0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ignored i=%0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) pulses++;
      checks++;
      if (out_valid !== 1'(i == 10)) begin
        errors++;
        $display("FAIL single_valid i=%0d got %b want %b", i, out_valid, (i == 10));
      end
      if (i == 10) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
          errors++;
          $display("FAIL single_result got q=%0d r=%0d z=%b want q=28 r=4 z=0",
                   quotient, remainder, div_by_zero);
        end
      end
      if (i == 0) drive(1, 8'd200, 4'd7); else drive(0, 8'd0, 4'd0);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_t[4];
    logic [3:0] b_t[4];
    logic [7:0] q_t[4];
    logic [3:0] r_t[4];
    a_t = '{8'd255, 8'd0, 8'd15, 8'd3};
    b_t = '{4'd1, 4'd15, 4'd15, 4'd9};
    q_t = '{8'd255, 8'd0, 8'd1, 8'd0};
    r_t = '{4'd0, 4'd0, 4'd0, 4'd3};
    for (int i = 0; i < 18; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'(i >= 10 && i < 14)) begin
        errors++;
        $display("FAIL b2b_valid i=%0d got %b want %b", i, out_valid, (i >= 10 && i < 14));
      end
      if (i >= 10 && i < 14) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {q_t[i-10], r_t[i-10], 1'b0}) begin
          errors++;
          $display("FAIL b2b_result i=%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                   i, quotient, remainder, div_by_zero, q_t[i-10], r_t[i-10]);
        end
      end
      if (i < 4) drive(1, a_t[i], b_t[i]); else drive(0, 8'd0, 4'd0);
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'(i == 10 || i == 11)) begin
        errors++;
        $display("FAIL dbz_valid i=%0d got %b want %b", i, out_valid, (i == 10 || i == 11));
      end
      if (i == 10) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 4'd0, 1'b1}) begin
          errors++;
          $display("FAIL dbz_result got q=%0d r=%0d z=%b want q=255 r=0 z=1",
                   quotient, remainder, div_by_zero);
        end
      end
      if (i == 11) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd10, 4'd0, 1'b0}) begin
          errors++;
          $display("FAIL dbz_follow got q=%0d r=%0d z=%b want q=10 r=0 z=0",
                   quotient, remainder, div_by_zero);
        end
      end
      if (i == 0) drive(1, 8'd5, 4'd0);
      else if (i == 1) drive(1, 8'd100, 4'd10);
      else drive(0, 8'd0, 4'd0);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] wq;
    logic [3:0] wr;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'(i >= 10 && i <= 16 && i % 2 == 0)) begin
        errors++;
        $display("FAIL alt_valid i=%0d got %b want %b", i, out_valid, (i >= 10 && i <= 16 && i % 2 == 0));
      end
      if (i >= 10) begin
        // Even offsets produce a result; odd ones must still show the last one.
        wq = (((i - 10) / 2) % 2 == 0 || i > 16) ? 8'd16 : 8'd9;
        wr = (((i - 10) / 2) % 2 == 0 || i > 16) ? 4'd2 : 4'd5;
        if (i > 16) begin wq = 8'd9; wr = 4'd5; end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {wq, wr, 1'b0}) begin
          errors++;
          $display("FAIL alt_result i=%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                   i, quotient, remainder, div_by_zero, wq, wr);
        end
      end
      if (i < 8 && i % 2 == 0) drive(1, (i % 4 == 0) ? 8'd50 : 8'd77, (i % 4 == 0) ? 4'd3 : 4'd8);
      else drive(0, 8'd0, 4'd0);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'(i == 15)) begin
        errors++;
        $display("FAIL rst_valid i=%0d got %b want %b", i, out_valid, (i == 15));
      end
      if (i >= 4 && i < 15) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== 13'd0) begin
          errors++;
          $display("FAIL rst_cleared i=%0d got q=%0d r=%0d z=%b want 0 0 0",
                   i, quotient, remainder, div_by_zero);
        end
      end
      if (i == 15) begin
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd4, 4'd1, 1'b0}) begin
          errors++;
          $display("FAIL rst_after got q=%0d r=%0d z=%b want q=4 r=1 z=0",
                   quotient, remainder, div_by_zero);
        end
      end
      rst = (i == 3);
      if (i < 3) drive(1, 8'($urandom_range(255)), 4'($urandom_range(15, 1)));
      else if (i == 5) drive(1, 8'd9, 4'd2);
      else drive(0, 8'd0, 4'd0);
    end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 10012; i++) begin
      tick();
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected cyc=%0d got q=%0d r=%0d want no result", cyc, quotient, remainder);
        end else begin
          e = expq.pop_front();
          if (e.due != cyc || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            errors++;
            $display("FAIL rand_result %0d/%0d cyc=%0d got q=%0d r=%0d z=%b want cyc=%0d q=%0d r=%0d z=%b",
                     e.a, e.b, cyc, quotient, remainder, div_by_zero, e.due, e.q, e.r, e.dbz);
          end
          if (e.b != 0) begin
            checks++;
            if (int'(quotient) * int'(e.b) + int'(remainder) != int'(e.a) || remainder >= e.b) begin
              errors++;
              $display("FAIL rand_identity %0d/%0d got q=%0d r=%0d want q*d+r=dividend and r<d",
                       e.a, e.b, quotient, remainder);
            end
          end
        end
      end else if (expq.size() != 0 && expq[0].due <= cyc) begin
        checks++;
        errors++;
        e = expq.pop_front();
        $display("FAIL rand_missing %0d/%0d cyc=%0d got out_valid=0 want 1", e.a, e.b, cyc);
      end
      if (i < 10000 && $urandom_range(9) < 8) begin
        a = 8'($urandom_range(255));
        b = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
        drive(1, a, b);
        expq.push_back(model(cyc + 10, a, b));
      end else begin
        drive(0, 8'd0, 4'd0);
      end
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got %0d outstanding want 0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_alternate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
